// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one UART TX datapath among
//            N byte requesters. Captures the winner's byte, stretches the TX
//            start pulse over START_LEN cycles, then follows Tx_Busy through
//            one frame before the next grant is allowed.
// Ports    : Clk, Reset (sync, active-low), Enable (gates new grants only),
//            Req[N], Data_In[N*WORD_LENGTH], Tx_Busy (already synchronised)
//            -> Ack[N] (1-cycle), Grant[N] (one-hot owner), Tx_Data,
//            Tx_Start, Busy (state != IDLE), Timeout_Err (1-cycle).
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int WORD_LENGTH = 8,
  parameter int START_LEN   = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic [N-1:0]             Req,
  input  logic [N*WORD_LENGTH-1:0] Data_In,
  input  logic                     Tx_Busy,
  output logic [N-1:0]             Ack,
  output logic [N-1:0]             Grant,
  output logic [WORD_LENGTH-1:0]   Tx_Data,
  output logic                     Tx_Start,
  output logic                     Busy,
  output logic                     Timeout_Err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(N);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [CW-1:0] C_START_INIT = CW'(START_LEN - 1);
  localparam logic [CW-1:0] C_TIMEOUT    = CW'(TIMEOUT);

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;     // first index searched next
  logic [N-1:0]           ack_q, ack_d;
  logic [N-1:0]           grant_q, grant_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   start_q, start_d;
  logic                   err_q, err_d;

  logic                   w_found;
  logic [PW-1:0]          w_win;
  logic [PW:0]            w_sum;
  logic                   w_grant_now;
  logic [CW-1:0]          w_cnt_inc;
  logic [N-1:0]           w_onehot;

  // Rotating search starting at ptr_q; the first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      if (!w_found && Req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
  end

  assign w_grant_now = (state_q == S_IDLE) && Enable && w_found;
  assign w_cnt_inc   = cnt_q + CW'(1);
  assign w_onehot    = N'(1) << w_win;

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (w_grant_now) state_d = S_START;
      S_START:     if (cnt_q == '0) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (Tx_Busy) begin
          state_d = S_WAIT_DONE;
        end else if (w_cnt_inc == C_TIMEOUT) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!Tx_Busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ack_d   = '0;
    err_d   = 1'b0;
    grant_d = grant_q;
    data_d  = data_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_now) begin
          ack_d   = w_onehot;
          grant_d = w_onehot;
          data_d  = Data_In[int'(w_win)*WORD_LENGTH +: WORD_LENGTH];
          start_d = 1'b1;
          cnt_d   = C_START_INIT;
          ptr_d   = (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          start_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_BUSY: begin
        // A busy flag already high on entry counts as the frame starting.
        if (!Tx_Busy) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == C_TIMEOUT) begin
            err_d   = 1'b1;
            grant_d = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!Tx_Busy) grant_d = '0;
      end
      default: begin
        grant_d = '0;
        start_d = 1'b0;
      end
    endcase
  end

  assign Ack         = ack_q;
  assign Grant       = grant_q;
  assign Tx_Data     = data_q;     // holds until the next grant
  assign Tx_Start    = start_q;
  assign Busy        = (state_q != S_IDLE);
  assign Timeout_Err = err_q;

endmodule
`default_nettype wire
